// File: rtl/wb_string_sequencer.sv
// wb_string_sequencer
// Writeback-stage controller for CMPS / REPNE CMPS. A string instruction
// that reaches writeback is held there and replayed as two micro-op phases
// (U1 then U2) per iteration. The block drives the datapath selects, writes
// the decremented count back to GPR3 and stalls the upstream stages until
// the instruction retires.
//
// Ports
//   CLK                        clock, rising-edge
//   RST                        asynchronous active-low reset
//   WB_V                       valid instruction in writeback
//   WB_IS_CMPS                 instruction is CMPS
//   WB_IS_REPNE                REPNE prefix present
//   WB_COUNT[COUNT_W]          count register value at entry
//   WB_ZF                      ZF from the compare (looked at in U2 only)
//   WB_FLUSH                   pipeline flush, aborts the sequence
//   CS_IS_CMPS_FIRST_UOP_ALL   first micro-op select (U1)
//   CS_IS_CMPS_SECOND_UOP_ALL  second micro-op select (U2)
//   CS_IS_FIRST_OF_REPNE_WB    first U1 of a REPNE instruction
//   CS_LD_GPR3_WB              count register write enable
//   COUNT_OUT[COUNT_W]         count register write data
//   REPNE_TERMINATION          one-cycle pulse on normal REPNE completion
//   WB_STALL                   hold upstream pipeline registers
module wb_string_sequencer #(
  parameter int COUNT_W = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               WB_V,
  input  logic               WB_IS_CMPS,
  input  logic               WB_IS_REPNE,
  input  logic [COUNT_W-1:0] WB_COUNT,
  input  logic               WB_ZF,
  input  logic               WB_FLUSH,
  output logic               CS_IS_CMPS_FIRST_UOP_ALL,
  output logic               CS_IS_CMPS_SECOND_UOP_ALL,
  output logic               CS_IS_FIRST_OF_REPNE_WB,
  output logic               CS_LD_GPR3_WB,
  output logic [COUNT_W-1:0] COUNT_OUT,
  output logic               REPNE_TERMINATION,
  output logic               WB_STALL
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    U1   = 2'd1,
    U2   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] cnt_q;
  logic               rep_q;
  logic               first_q;

  logic [COUNT_W-1:0] cnt_dec;
  logic               start;
  logic               load;
  logic               dec;
  logic               clr_first;

  // Next-state and output decode
  always_comb begin
    state_d                   = state_q;
    load                      = 1'b0;
    dec                       = 1'b0;
    clr_first                 = 1'b0;
    CS_IS_CMPS_FIRST_UOP_ALL  = 1'b0;
    CS_IS_CMPS_SECOND_UOP_ALL = 1'b0;
    CS_IS_FIRST_OF_REPNE_WB   = 1'b0;
    CS_LD_GPR3_WB             = 1'b0;
    COUNT_OUT                 = '0;
    REPNE_TERMINATION         = 1'b0;
    WB_STALL                  = 1'b0;

    cnt_dec = cnt_q - COUNT_W'(1);
    // Qualified by RST so that every output reads 0 while reset is held,
    // even with a CMPS sitting on the inputs.
    start   = RST & WB_V & WB_IS_CMPS & ~WB_FLUSH;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (WB_IS_REPNE && (WB_COUNT == '0)) begin
            // Zero-iteration REPNE: retires immediately, nothing to replay.
            REPNE_TERMINATION = 1'b1;
          end else begin
            load     = 1'b1;
            WB_STALL = 1'b1;
            state_d  = U1;
          end
        end
      end
      U1: begin
        CS_IS_CMPS_FIRST_UOP_ALL = 1'b1;
        CS_IS_FIRST_OF_REPNE_WB  = first_q;
        WB_STALL                 = 1'b1;
        state_d                  = U2;
      end
      U2: begin
        CS_IS_CMPS_SECOND_UOP_ALL = 1'b1;
        WB_STALL                  = 1'b1;
        clr_first                 = 1'b1;
        if (rep_q) begin
          CS_LD_GPR3_WB = 1'b1;
          COUNT_OUT     = cnt_dec;
          dec           = 1'b1;
        end
        if (!rep_q || (cnt_dec == '0) || WB_ZF) state_d = DONE;
        else                                    state_d = U1;
      end
      DONE: begin
        // Stall drops here so the instruction retires on this edge.
        REPNE_TERMINATION = rep_q;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush beats anything the sequence wanted to commit this cycle.
    if ((state_q != IDLE) && WB_FLUSH) begin
      state_d           = IDLE;
      dec               = 1'b0;
      CS_LD_GPR3_WB     = 1'b0;
      COUNT_OUT         = '0;
      REPNE_TERMINATION = 1'b0;
      WB_STALL          = 1'b0;
    end
  end

  // State and sequence registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rep_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cnt_q   <= WB_COUNT;
        rep_q   <= WB_IS_REPNE;
        first_q <= WB_IS_REPNE;
      end else begin
        if (dec)       cnt_q   <= cnt_dec;
        if (clr_first) first_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_string_sequencer.sv
module tb_wb_string_sequencer;

  localparam int COUNT_W = 32;

  logic               CLK;
  logic               RST;
  logic               WB_V;
  logic               WB_IS_CMPS;
  logic               WB_IS_REPNE;
  logic [COUNT_W-1:0] WB_COUNT;
  logic               WB_ZF;
  logic               WB_FLUSH;
  logic               CS_IS_CMPS_FIRST_UOP_ALL;
  logic               CS_IS_CMPS_SECOND_UOP_ALL;
  logic               CS_IS_FIRST_OF_REPNE_WB;
  logic               CS_LD_GPR3_WB;
  logic [COUNT_W-1:0] COUNT_OUT;
  logic               REPNE_TERMINATION;
  logic               WB_STALL;

  int checks = 0;
  int errors = 0;

  wb_string_sequencer #(.COUNT_W(COUNT_W)) dut (
    .CLK                       (CLK),
    .RST                       (RST),
    .WB_V                      (WB_V),
    .WB_IS_CMPS                (WB_IS_CMPS),
    .WB_IS_REPNE               (WB_IS_REPNE),
    .WB_COUNT                  (WB_COUNT),
    .WB_ZF                     (WB_ZF),
    .WB_FLUSH                  (WB_FLUSH),
    .CS_IS_CMPS_FIRST_UOP_ALL  (CS_IS_CMPS_FIRST_UOP_ALL),
    .CS_IS_CMPS_SECOND_UOP_ALL (CS_IS_CMPS_SECOND_UOP_ALL),
    .CS_IS_FIRST_OF_REPNE_WB   (CS_IS_FIRST_OF_REPNE_WB),
    .CS_LD_GPR3_WB             (CS_LD_GPR3_WB),
    .COUNT_OUT                 (COUNT_OUT),
    .REPNE_TERMINATION         (REPNE_TERMINATION),
    .WB_STALL                  (WB_STALL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Outputs packed as {u1, u2, first, ld, term, stall, count_out}
  task automatic cmp(input string tag, input bit u1, input bit u2, input bit f,
                     input bit ld, input logic [COUNT_W-1:0] co, input bit term,
                     input bit st);
    logic [COUNT_W+5:0] obs;
    logic [COUNT_W+5:0] exp;
    obs = {CS_IS_CMPS_FIRST_UOP_ALL, CS_IS_CMPS_SECOND_UOP_ALL, CS_IS_FIRST_OF_REPNE_WB,
           CS_LD_GPR3_WB, REPNE_TERMINATION, WB_STALL, COUNT_OUT};
    exp = {u1, u2, f, ld, term, st, co};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed u1u2 f ld term stall=%b%b %b %b %b %b cnt=%0d required=%b%b %b %b %b %b cnt=%0d",
             tag, obs[COUNT_W+5], obs[COUNT_W+4], obs[COUNT_W+3], obs[COUNT_W+2],
             obs[COUNT_W+1], obs[COUNT_W], COUNT_OUT, u1, u2, f, ld, term, st, co);
    end
  endtask

  // Check at the falling edge, then advance to just after the next rising edge.
  task automatic chk(input string tag, input bit u1, input bit u2, input bit f,
                     input bit ld, input logic [COUNT_W-1:0] co, input bit term,
                     input bit st);
    @(negedge CLK);
    cmp(tag, u1, u2, f, ld, co, term, st);
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit v, input bit cmps, input bit rep,
                       input logic [COUNT_W-1:0] count, input bit zf, input bit fl);
    WB_V        = v;
    WB_IS_CMPS  = cmps;
    WB_IS_REPNE = rep;
    WB_COUNT    = count;
    WB_ZF       = zf;
    WB_FLUSH    = fl;
  endtask

  initial begin
    RST = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    cmp("reset_state", 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Non-CMPS passes through with no stall
    drive(1, 0, 1, 7, 0, 0);
    chk("noncmps", 0, 0, 0, 0, 0, 0, 0);

    // Non-REP CMPS, count 5
    drive(1, 1, 0, 5, 0, 0);
    chk("nr_T",  0, 0, 0, 0, 0, 0, 1);
    chk("nr_U1", 1, 0, 0, 0, 0, 0, 1);
    chk("nr_U2", 0, 1, 0, 0, 0, 0, 1);
    chk("nr_DONE", 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("nr_idle", 0, 0, 0, 0, 0, 0, 0);

    // REPNE, count 3, ZF always 0
    drive(1, 1, 1, 3, 0, 0);
    chk("r3_T",   0, 0, 0, 0, 0, 0, 1);
    chk("r3_U1a", 1, 0, 1, 0, 0, 0, 1);
    chk("r3_U2a", 0, 1, 0, 1, 2, 0, 1);
    chk("r3_U1b", 1, 0, 0, 0, 0, 0, 1);
    chk("r3_U2b", 0, 1, 0, 1, 1, 0, 1);
    chk("r3_U1c", 1, 0, 0, 0, 0, 0, 1);
    chk("r3_U2c", 0, 1, 0, 1, 0, 0, 1);
    chk("r3_DONE", 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("r3_idle", 0, 0, 0, 0, 0, 0, 0);

    // REPNE, count 10, ZF=1 in second U2
    drive(1, 1, 1, 10, 0, 0);
    chk("r10_T",   0, 0, 0, 0, 0, 0, 1);
    chk("r10_U1a", 1, 0, 1, 0, 0, 0, 1);
    chk("r10_U2a", 0, 1, 0, 1, 9, 0, 1);
    chk("r10_U1b", 1, 0, 0, 0, 0, 0, 1);
    WB_ZF = 1'b1;
    chk("r10_U2b", 0, 1, 0, 1, 8, 0, 1);
    WB_ZF = 1'b0;
    chk("r10_DONE", 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("r10_idle", 0, 0, 0, 0, 0, 0, 0);

    // REPNE with count 0: terminate in the start cycle
    drive(1, 1, 1, 0, 0, 0);
    chk("r0_T", 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("r0_idle", 0, 0, 0, 0, 0, 0, 0);

    // REPNE, count 4, flush with ZF=1 in the second U2
    drive(1, 1, 1, 4, 0, 0);
    chk("fl_T",   0, 0, 0, 0, 0, 0, 1);
    chk("fl_U1a", 1, 0, 1, 0, 0, 0, 1);
    chk("fl_U2a", 0, 1, 0, 1, 3, 0, 1);
    chk("fl_U1b", 1, 0, 0, 0, 0, 0, 1);
    WB_ZF    = 1'b1;
    WB_FLUSH = 1'b1;
    chk("fl_U2b", 0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("fl_idle", 0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset during U2 of a REPNE sequence
    drive(1, 1, 1, 5, 0, 0);
    chk("rs_T",  0, 0, 0, 0, 0, 0, 1);
    chk("rs_U1", 1, 0, 1, 0, 0, 0, 1);
    #1;
    cmp("rs_U2", 0, 1, 0, 1, 4, 0, 1);
    RST = 1'b0;
    #1;
    cmp("rs_async", 0, 0, 0, 0, 0, 0, 0);
    chk("rs_held", 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("rs_idle", 0, 0, 0, 0, 0, 0, 0);

    // Clean restart after reset
    drive(1, 1, 0, 2, 0, 0);
    chk("rs2_T",  0, 0, 0, 0, 0, 0, 1);
    chk("rs2_U1", 1, 0, 0, 0, 0, 0, 1);
    chk("rs2_U2", 0, 1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("rs2_DONE", 0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
